// File: rtl/cpu_controller.sv
// SAP-1 style control sequencer: fetch/execute T-state machine with a Moore
// decode of state and opcode onto the CPU's bus-enable and load strobes.
module cpu_controller #(
   parameter bit HALT_ON_ILLEGAL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   input  logic       zf,
   input  logic       cf,
   output logic       cp,
   output logic       ep,
   output logic       lp,
   output logic       lm,
   output logic       ce,
   output logic       li,
   output logic       la,
   output logic       ea,
   output logic       lb,
   output logic       eu,
   output logic       su,
   output logic       lo,
   output logic       hlt,
   output logic [2:0] tstate
);

   typedef enum logic [2:0] {
      ST_T0   = 3'd0,
      ST_T1   = 3'd1,
      ST_T2   = 3'd2,
      ST_T3   = 3'd3,
      ST_T4   = 3'd4,
      ST_T5   = 3'd5,
      ST_HALT = 3'd7
   } state_e;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   state_e state_q;
   state_e state_d;

   logic op_legal;
   logic branch_taken;

   always_comb begin
      op_legal = 1'b0;
      case (opcode)
         OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_LDI,
         OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: op_legal = 1'b1;
         default:                              op_legal = 1'b0;
      endcase
   end

   // Only meaningful in T3 of a conditional jump; elsewhere it is not consulted.
   always_comb begin
      branch_taken = 1'b0;
      if (opcode == OP_JC)
         branch_taken = cf;
      else if (opcode == OP_JZ)
         branch_taken = zf;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= ST_T0;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = ST_T0;
      case (state_q)
         ST_T0: state_d = ST_T1;
         ST_T1: state_d = ST_T2;
         ST_T2: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_LDI,
               OP_JMP, OP_JC, OP_JZ:   state_d = ST_T3;
               OP_HLT:                 state_d = ST_HALT;
               default:                state_d = (!op_legal && HALT_ON_ILLEGAL) ? ST_HALT : ST_T0;
            endcase
         end
         ST_T3: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB: state_d = ST_T4;
               default:                state_d = ST_T0;
            endcase
         end
         ST_T4: begin
            case (opcode)
               OP_ADD, OP_SUB: state_d = ST_T5;
               default:        state_d = ST_T0;
            endcase
         end
         ST_T5:   state_d = ST_T0;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_T0;
      endcase
   end

   always_comb begin
      cp  = 1'b0;
      ep  = 1'b0;
      lp  = 1'b0;
      lm  = 1'b0;
      ce  = 1'b0;
      li  = 1'b0;
      la  = 1'b0;
      ea  = 1'b0;
      lb  = 1'b0;
      eu  = 1'b0;
      su  = 1'b0;
      lo  = 1'b0;
      hlt = 1'b0;
      case (state_q)
         ST_T0: begin
            ep = 1'b1;
            lm = 1'b1;
         end
         ST_T1: begin
            ce = 1'b1;
            li = 1'b1;
            cp = 1'b1;
         end
         ST_T2: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_LDI,
               OP_JMP, OP_JC, OP_JZ: begin
                  ep = 1'b1;
                  lm = 1'b1;
               end
               OP_OUT: begin
                  ea = 1'b1;
                  lo = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T3: begin
            // The operand address is fetched into MAR here, so the PC steps past it.
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB: begin
                  ce = 1'b1;
                  lm = 1'b1;
                  cp = 1'b1;
               end
               OP_LDI: begin
                  ce = 1'b1;
                  la = 1'b1;
                  cp = 1'b1;
               end
               OP_JMP: begin
                  ce = 1'b1;
                  lp = 1'b1;
               end
               OP_JC, OP_JZ: begin
                  ce = branch_taken;
                  lp = branch_taken;
                  cp = !branch_taken;
               end
               default: ;
            endcase
         end
         ST_T4: begin
            case (opcode)
               OP_LDA: begin
                  ce = 1'b1;
                  la = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ce = 1'b1;
                  lb = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T5: begin
            eu = 1'b1;
            la = 1'b1;
            su = (opcode == OP_SUB);
         end
         ST_HALT: hlt = 1'b1;
         default: ;
      endcase
   end

   assign tstate = state_q;

endmodule
